mux_2x1_8bit_arbiter: RTL and testbench

Round-robin arbiter that shares one 8-bit `mux_2x1_8bit` datapath between two valid/ready requesters, X and Y. It owns the mux select `s`, grants the channel to one requester at a time with a bounded burst length, and registers the selected byte into a single output stage with valid/ready handshake. It sits between two byte producers and one downstream consumer.

---
 rtl/mux_2x1_8bit_arbiter.sv | 125 ++++++++++++
 tb/tb_mux_2x1_8bit_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_2x1_8bit_arbiter.sv
// Round-robin arbiter sharing one 8-bit 2:1 mux between requesters X and Y,
// with bounded bursts and a single registered valid/ready output stage.

module mux_2x1_8bit (
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic       s,
   output logic [7:0] m
);
   assign m = s ? y : x;
endmodule

module mux_2x1_8bit_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       x_valid,
   input  logic [7:0] x_data,
   output logic       x_ready,
   input  logic       y_valid,
   input  logic [7:0] y_data,
   output logic       y_ready,
   output logic       s,
   output logic       m_valid,
   output logic [7:0] m_data,
   input  logic       m_ready
);
   typedef enum logic [1:0] {IDLE, GRANT_X, GRANT_Y} state_t;

   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
   localparam logic [3:0] HOLD_PRE = 4'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic [3:0] hold_q, hold_d;
   logic       last_y_q, last_y_d;
   logic       s_q, s_d;
   logic       m_valid_q, m_valid_d;
   logic [7:0] m_data_q, m_data_d;

   logic       load;
   logic       xfer;
   logic       burst_done;
   logic [7:0] mux_out;

   mux_2x1_8bit u_mux (
      .x (x_data),
      .y (y_data),
      .s (s_q),
      .m (mux_out)
   );

   // Readies are combinational on m_ready so a stall blocks transfers in the same cycle.
   assign load    = !m_valid_q || m_ready;
   assign x_ready = (state_q == GRANT_X) && load;
   assign y_ready = (state_q == GRANT_Y) && load;
   assign xfer    = (x_valid && x_ready) || (y_valid && y_ready);

   assign burst_done = (hold_q == HOLD_MAX) || (xfer && (hold_q == HOLD_PRE));

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      last_y_d  = last_y_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;

      if (xfer) begin
         m_valid_d = 1'b1;
         m_data_d  = mux_out;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (x_valid && y_valid) state_d = last_y_q ? GRANT_X : GRANT_Y;
            else if (x_valid)       state_d = GRANT_X;
            else if (y_valid)       state_d = GRANT_Y;
         end
         GRANT_X: begin
            if (y_valid && (burst_done || !x_valid)) state_d = GRANT_Y;
            else if (!x_valid)                       state_d = IDLE;
            else if (xfer && hold_q != HOLD_MAX)     hold_d  = hold_q + 4'd1;
         end
         GRANT_Y: begin
            if (x_valid && (burst_done || !y_valid)) state_d = GRANT_X;
            else if (!y_valid)                       state_d = IDLE;
            else if (xfer && hold_q != HOLD_MAX)     hold_d  = hold_q + 4'd1;
         end
         default: state_d = IDLE;
      endcase

      // Any grant change restarts the burst count and remembers who won.
      if (state_d != state_q) begin
         hold_d = 4'd0;
         if (state_d == GRANT_X) last_y_d = 1'b0;
         if (state_d == GRANT_Y) last_y_d = 1'b1;
      end

      s_d = (state_d == GRANT_Y);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         hold_q    <= 4'd0;
         last_y_q  <= 1'b1;
         s_q       <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= 8'h00;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         last_y_q  <= last_y_d;
         s_q       <= s_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
      end
   end

   assign s       = s_q;
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
endmodule

// File: tb/tb_mux_2x1_8bit_arbiter.sv
// Self-checking bench for mux_2x1_8bit_arbiter: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a behavioural model.

module tb_mux_2x1_8bit_arbiter;
   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       x_valid, y_valid, m_ready;
   logic [7:0] x_data, y_data;
   logic       x_ready, y_ready, s, m_valid;
   logic [7:0] m_data;

   always #5 clk = ~clk;

   mux_2x1_8bit_arbiter #(.MAX_HOLD(MAXH)) dut (
      .clk     (clk),
      .reset   (reset),
      .x_valid (x_valid),
      .x_data  (x_data),
      .x_ready (x_ready),
      .y_valid (y_valid),
      .y_data  (y_data),
      .y_ready (y_ready),
      .s       (s),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_ready (m_ready)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: owner 0=none, 1=X, 2=Y; cnt = transfers in current burst.
   int         md_owner, md_cnt, nx_owner, nx_cnt;
   logic       md_last_y, nx_last;
   logic       md_v, nx_v;
   logic [7:0] md_d, nx_d;
   logic       md_can, md_tx, md_ty, mine, other;
   int         took;

   always_comb begin
      md_can = !md_v || m_ready;
      md_tx  = x_valid && (md_owner == 1) && md_can;
      md_ty  = y_valid && (md_owner == 2) && md_can;
      took   = (md_tx || md_ty) ? 1 : 0;
      nx_v   = md_v;
      nx_d   = md_d;
      if (md_tx || md_ty) begin
         nx_v = 1'b1;
         nx_d = md_tx ? x_data : y_data;
      end else if (m_ready) begin
         nx_v = 1'b0;
      end
      nx_owner = md_owner;
      nx_cnt   = md_cnt;
      nx_last  = md_last_y;
      mine     = (md_owner == 1) ? x_valid : y_valid;
      other    = (md_owner == 1) ? y_valid : x_valid;
      if (md_owner == 0) begin
         if (x_valid && y_valid) nx_owner = md_last_y ? 1 : 2;
         else if (x_valid)       nx_owner = 1;
         else if (y_valid)       nx_owner = 2;
      end else if (other && (!mine || md_cnt + took >= MAXH)) begin
         nx_owner = 3 - md_owner;
      end else if (!mine) begin
         nx_owner = 0;
      end else begin
         nx_cnt = (md_cnt + took > MAXH) ? MAXH : md_cnt + took;
      end
      if (nx_owner != md_owner) begin
         nx_cnt = 0;
         if (nx_owner != 0) nx_last = (nx_owner == 2);
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         md_owner  <= 0;
         md_cnt    <= 0;
         md_last_y <= 1'b1;
         md_v      <= 1'b0;
         md_d      <= 8'h00;
      end else begin
         md_owner  <= nx_owner;
         md_cnt    <= nx_cnt;
         md_last_y <= nx_last;
         md_v      <= nx_v;
         md_d      <= nx_d;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("x_ready", x_ready, (md_owner == 1) && md_can);
         chk("y_ready", y_ready, (md_owner == 2) && md_can);
         chk("s",       s,       md_owner == 2);
         chk("m_valid", m_valid, md_v);
         chk("m_data",  m_data,  md_d);
      end
   end

   // Producers and consumer-side stream capture
   logic [7:0] xs[256];
   logic [7:0] ys[256];
   int         xi, yi, x_len, y_len;
   logic       x_en, y_en, acc_x, acc_y;
   logic [7:0] obs[$];

   task automatic drive();
      x_valid = x_en && (xi < x_len);
      y_valid = y_en && (yi < y_len);
      x_data  = xs[xi % 256];
      y_data  = ys[yi % 256];
   endtask

   task automatic begin_cycle();
      drive();
      @(negedge clk);
      acc_x = x_valid && x_ready;
      acc_y = y_valid && y_ready;
      if (m_valid && m_ready) obs.push_back(m_data);
   endtask

   task automatic end_cycle();
      @(posedge clk);
      #1;
      if (acc_x) xi++;
      if (acc_y) yi++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      x_en  = 1'b0;
      y_en  = 1'b0;
      xi    = 0;
      yi    = 0;
      begin_cycle();
      chk("rst m_valid", m_valid, 0);
      chk("rst m_data",  m_data,  8'h00);
      chk("rst s",       s,       0);
      chk("rst x_ready", x_ready, 0);
      chk("rst y_ready", y_ready, 0);
      end_cycle();
      begin_cycle();
      end_cycle();
      reset = 1'b0;
      obs.delete();
      begin_cycle();
      chk("idle m_valid", m_valid, 0);
      chk("idle x_ready", x_ready, 0);
      end_cycle();
      obs.delete();
   endtask

   task automatic fill_ab();
      for (int i = 0; i < 256; i++) begin
         xs[i] = 8'(8'hA0 + i);
         ys[i] = 8'(8'hB0 + i);
      end
      x_len = 256;
      y_len = 256;
   endtask

   logic [7:0] exp_rr[12];
   logic [7:0] exp_st[6];

   initial begin
      reset   = 1'b1;
      m_ready = 1'b1;
      x_en    = 1'b0;
      y_en    = 1'b0;
      xi      = 0;
      yi      = 0;
      x_len   = 0;
      y_len   = 0;
      for (int i = 0; i < 256; i++) begin
         xs[i] = 8'h00;
         ys[i] = 8'h00;
      end
      drive();
      do_reset();

      // Only X valid: 11, 22, 33
      xs[0] = 8'h11; xs[1] = 8'h22; xs[2] = 8'h33;
      x_len = 3; y_len = 0; x_en = 1'b1;
      for (int c = 0; c < 8; c++) begin
         begin_cycle();
         chk("xonly s", s, 0);
         if (c == 0) chk("xonly c0 x_ready", x_ready, 0);
         if (c == 1) chk("xonly c1 x_ready", x_ready, 1);
         if (c == 2) chk("xonly c2 m_data", {m_valid, m_data}, {1'b1, 8'h11});
         if (c == 3) chk("xonly c3 m_data", {m_valid, m_data}, {1'b1, 8'h22});
         if (c == 4) chk("xonly c4 m_data", {m_valid, m_data}, {1'b1, 8'h33});
         end_cycle();
      end

      // Both valid continuously: bursts of 4, then reset mid-stream
      do_reset();
      fill_ab();
      x_en = 1'b1; y_en = 1'b1;
      for (int c = 0; c < 14; c++) begin
         begin_cycle();
         if (c == 4) chk("rr c4 s", s, 0);
         if (c == 5) chk("rr c5 s", s, 1);
         if (c == 9) chk("rr c9 s", s, 0);
         end_cycle();
      end
      exp_rr = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                 8'hA4, 8'hA5, 8'hA6, 8'hA7};
      chk("rr count", obs.size(), 12);
      for (int i = 0; i < 12 && i < obs.size(); i++) chk($sformatf("rr byte%0d", i), obs[i], exp_rr[i]);
      chk("pre-reset m_valid", m_valid, 1);
      do_reset();

      // Stall while A1 is in the output register
      fill_ab();
      x_en = 1'b1; y_en = 1'b1;
      for (int c = 0; c < 12; c++) begin
         m_ready = !(c >= 3 && c <= 5);
         begin_cycle();
         if (c >= 3 && c <= 5) begin
            chk("stall m_data", {m_valid, m_data}, {1'b1, 8'hA1});
            chk("stall x_ready", x_ready, 0);
         end
         end_cycle();
      end
      m_ready = 1'b1;
      exp_st = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1};
      chk("stall count", obs.size() >= 6, 1);
      for (int i = 0; i < 6 && i < obs.size(); i++) chk($sformatf("stall byte%0d", i), obs[i], exp_st[i]);
      do_reset();

      // X drops after 2 bytes while Y waits
      fill_ab();
      x_len = 2;
      x_en = 1'b1; y_en = 1'b1;
      for (int c = 0; c < 7; c++) begin
         begin_cycle();
         if (c == 3) chk("drop c3 m_data", m_data, 8'hA1);
         if (c == 4) chk("drop c4 y_ready", {y_ready, s}, 2'b11);
         if (c == 5) chk("drop c5 m_data", {m_valid, m_data}, {1'b1, 8'hB0});
         end_cycle();
      end
      do_reset();

      // Simultaneous requests: X first, then Y on the next simultaneous request
      fill_ab();
      for (int c = 0; c < 7; c++) begin
         x_en = (c < 2) || (c >= 4);
         y_en = x_en;
         begin_cycle();
         if (c == 1) chk("sim c1 grant", {x_ready, y_ready}, 2'b10);
         if (c == 3) chk("sim c3 idle",  {x_ready, y_ready}, 2'b00);
         if (c == 5) chk("sim c5 grant", {x_ready, y_ready, s}, 3'b011);
         end_cycle();
      end
      do_reset();

      // Randomized run against the model
      for (int i = 0; i < 256; i++) begin
         xs[i] = 8'($urandom);
         ys[i] = 8'($urandom);
      end
      x_len = 1 << 30;
      y_len = 1 << 30;
      for (int c = 0; c < 4000; c++) begin
         reset   = ($urandom_range(0, 199) == 0);
         x_en    = (c % 400 < 200) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0);
         y_en    = ($urandom_range(0, 3) != 0);
         m_ready = ($urandom_range(0, 3) != 0);
         begin_cycle();
         end_cycle();
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
